sevenseg_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment display controller for the Nexys A7 (or any common-anode multi-digit display). It drives NUM_DIGITS hexadecimal digits through one shared set of active-low segment lines by scanning active-low anodes. Beyond plain decoding it adds per-digit decimal points, per-digit blanking, optional leading-zero suppression, a snapshot of the input per scan frame, and anode guard time against ghosting. It sits between the datapath and the board pins, replacing per-digit combinational decoders.

---
 rtl/sevenseg_mux.sv | 130 +++++++++++++
 tb/tb_sevenseg_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment controller for common-anode displays.
// Scans NUM_DIGITS hex digits through shared active-low segment lines.
// Features: per-digit decimal point, per-digit blanking, leading-zero
// suppression, a per-frame input snapshot and an anode guard interval.
module sevenseg_mux #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int GUARD_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] d,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    lz_en,
   output logic [6:0]              segs_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] GUARD_C  = CW'(GUARD_CYCLES);

   // Scan position
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;

   // Per-frame snapshot of the inputs
   logic [4*NUM_DIGITS-1:0] d_s;
   logic [NUM_DIGITS-1:0]   dp_s;
   logic [NUM_DIGITS-1:0]   blank_s;
   logic                    lz_s;

   // Per-digit views of the snapshot
   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] sup;
   logic [NUM_DIGITS-1:0] sel;
   logic                  lit;

   // Hex digit to segment pattern, a..g on bits 6..0, active high
   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1110011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b0001101;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   // Nibble split, digit select and leading-zero detection per digit.
   // Each digit checks its own nibble and everything to its left, so a
   // digit is blanked only when no nonzero digit sits above it.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi] = d_s[4*gi+3 : 4*gi];
         assign sel[gi] = (idx == IW'(gi));
         if (gi == 0) begin : g_first
            assign sup[gi] = 1'b0;
         end else begin : g_upper
            assign sup[gi] = lz_s && (d_s[4*NUM_DIGITS-1 : 4*gi] == '0);
         end
      end
   endgenerate

   // Current digit is lit once the guard interval has elapsed
   assign lit = (cnt >= GUARD_C) && !blank_s[idx];

   // Slot counter and digit index advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == LAST_CNT) begin
         cnt <= '0;
         idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Capture the live inputs at the start of each frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_s     <= '0;
         dp_s    <= '0;
         blank_s <= '0;
         lz_s    <= 1'b0;
      end else if (cnt == '0 && idx == '0) begin
         d_s     <= d;
         dp_s    <= dp;
         blank_s <= blank;
         lz_s    <= lz_en;
      end
   end

   // Registered pin drive: one anode at most, dark during guard or blank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_n   <= '1;
         segs_n <= 7'h7F;
         dp_n   <= 1'b1;
      end else if (lit) begin
         an_n   <= ~sel;
         segs_n <= sup[idx] ? 7'h7F : ~hex_seg(nib[idx]);
         dp_n   <= ~dp_s[idx];
      end else begin
         an_n   <= '1;
         segs_n <= 7'h7F;
         dp_n   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench for sevenseg_mux (4 digits, 8-cycle slots, 2 guard cycles).
// Stimulus pushes tagged expected pin states; a negedge monitor pops and
// compares the entry whose tag matches the current clock count.
module tb_sevenseg_mux;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int GC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   d;
   logic [3:0]    dp;
   logic [3:0]    blank;
   logic          lz_en;
   logic [6:0]    segs_n;
   logic          dp_n;
   logic [3:0]    an_n;

   sevenseg_mux #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .GUARD_CYCLES(GC)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .dp    (dp),
      .blank (blank),
      .lz_en (lz_en),
      .segs_n(segs_n),
      .dp_n  (dp_n),
      .an_n  (an_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         tag;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      string      name;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         pcyc = 0;
   int         errors = 0;
   int         checks = 0;
   bit         timed_out = 1'b0;
   logic [6:0] seg_tab [16];

   // Decoded (active-high) patterns, hand-copied from the digit table
   initial begin
      seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                  7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                  7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111};
   end

   // Count rising edges; a sample at negedge belongs to the last edge
   always @(posedge clk) pcyc <= pcyc + 1;

   // Monitor: pin sanity every cycle, scoreboard entries when their tag is due
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(~an_n)) begin
         errors++;
         $display("FAIL onehot tag=%0d an_n=%b required at most one low", pcyc, an_n);
      end
      while (q.size() > 0 && q[0].tag < pcyc) begin
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed %s tag=%0d not sampled (now %0d)", e.name, e.tag, pcyc);
      end
      if (q.size() > 0 && q[0].tag == pcyc) begin
         e = q.pop_front();
         checks++;
         if (an_n !== e.an || segs_n !== e.seg || dp_n !== e.dp) begin
            errors++;
            $display("FAIL %s tag=%0d got an_n=%b segs_n=%b dp_n=%b required an_n=%b segs_n=%b dp_n=%b",
                     e.name, e.tag, an_n, segs_n, dp_n, e.an, e.seg, e.dp);
         end else begin
            $display("chk %s tag=%0d an_n=%b segs_n=%b dp_n=%b ok",
                     e.name, e.tag, an_n, segs_n, dp_n);
         end
      end
      if (timed_out) begin
         timed_out = 1'b0;
         checks++;
         errors++;
         $display("FAIL drain queue still holds %0d entries, required 0", q.size());
      end
   end

   task automatic push_dark(input int tag, input string nm);
      exp_t x;
      x.tag = tag; x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1; x.name = nm;
      q.push_back(x);
   endtask

   // One digit slot: GC dark cycles then lit cycles, unless blanked
   task automatic push_slot(input int base, input int digit, input logic [3:0] val,
                            input bit dpf, input bit blk, input bit sp,
                            input int last, input string nm);
      exp_t       x;
      logic [3:0] one;
      one = 4'b0001;
      for (int c = 0; c < RD; c++) begin
         x.tag  = base + digit*RD + c;
         x.name = $sformatf("%s_d%0d_c%0d", nm, digit, c);
         if (x.tag <= last) begin
            if (c < GC || blk) begin
               x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1;
            end else begin
               x.an  = ~(one << digit);
               x.seg = sp ? 7'h7F : ~seg_tab[val];
               x.dp  = ~dpf;
            end
            q.push_back(x);
         end
      end
   endtask

   task automatic push_frame(input int base, input logic [15:0] dv, input logic [3:0] dpv,
                             input logic [3:0] blv, input logic [3:0] supv,
                             input int last, input string nm);
      for (int i = 0; i < ND; i++)
         push_slot(base, i, dv[4*i +: 4], dpv[i], blv[i], supv[i], last, nm);
   endtask

   // Advance to 2 time units after rising edge number t
   task automatic wait_tag(input int t);
      while (pcyc < t) begin
         @(posedge clk);
         #2;
      end
   endtask

   localparam int NOLIM = 1 << 30;

   initial begin
      int b;
      int b2;
      d = 16'h1234; dp = 4'h0; blank = 4'h0; lz_en = 1'b0; rst = 1'b1;
      @(posedge clk);
      #2;
      // Reset held: all dark
      wait_tag(3);
      push_dark(4, "rst_a");
      push_dark(5, "rst_b");
      wait_tag(5);
      rst = 1'b0;
      b = 6;
      push_frame(b, 16'h1234, 4'h0, 4'h0, 4'h0, NOLIM, "f0_reset");
      // Scan order
      wait_tag(b + 5);
      d = 16'hA5F0;
      push_frame(b + 32, 16'hA5F0, 4'h0, 4'h0, 4'h0, NOLIM, "f1_scan");
      // Snapshot: mid-frame change only lands in the following frame
      wait_tag(b + 40);
      d = 16'h1111;
      push_frame(b + 64, 16'h1111, 4'h0, 4'h0, 4'h0, NOLIM, "f2_snap");
      wait_tag(b + 81);
      d = 16'h2222;
      push_frame(b + 96, 16'h2222, 4'h0, 4'h0, 4'h0, NOLIM, "f3_snap");
      // Blank and decimal point
      wait_tag(b + 100);
      blank = 4'b0100; dp = 4'b0001;
      push_frame(b + 128, 16'h2222, 4'b0001, 4'b0100, 4'h0, NOLIM, "f4_blkdp");
      // Leading-zero suppression
      wait_tag(b + 135);
      blank = 4'h0; dp = 4'h0; lz_en = 1'b1; d = 16'h0070;
      push_frame(b + 160, 16'h0070, 4'h0, 4'h0, 4'b1100, NOLIM, "f5_lz");
      wait_tag(b + 170);
      d = 16'h0000;
      push_frame(b + 192, 16'h0000, 4'h0, 4'h0, 4'b1110, NOLIM, "f6_lz0");
      // Mid-slot reset at idx=3, cnt=5
      wait_tag(b + 200);
      push_frame(b + 224, 16'h0000, 4'h0, 4'h0, 4'b1110, b + 251, "f7_pre");
      wait_tag(b + 230);
      d = 16'h1234; lz_en = 1'b0;
      push_dark(b + 252, "midrst_a");
      push_dark(b + 253, "midrst_b");
      wait_tag(b + 252);
      rst = 1'b1;
      wait_tag(b + 253);
      rst = 1'b0;
      b2 = b + 254;
      push_frame(b2, 16'h1234, 4'h0, 4'h0, 4'h0, NOLIM, "r0_restart");
      // Remaining glyphs
      wait_tag(b2 + 5);
      d = 16'h69E8;
      push_frame(b2 + 32, 16'h69E8, 4'h0, 4'h0, 4'h0, NOLIM, "r1_glyph");
      wait_tag(b2 + 40);
      d = 16'hDCB0;
      push_frame(b2 + 64, 16'hDCB0, 4'h0, 4'h0, 4'h0, NOLIM, "r2_glyph");
      // Drain with a bounded wait
      for (int i = 0; i < 200 && q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (q.size() > 0) timed_out = 1'b1;
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
